// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: branch type codes, counter encodings and table geometry helpers
package branch_predictor_pkg;
  localparam logic [3:0] BR_JAL  = 4'd0;
  localparam logic [3:0] BR_JALR = 4'd1;
  localparam logic [3:0] BR_BEQ  = 4'd2;
  localparam logic [3:0] BR_BNE  = 4'd3;
  localparam logic [3:0] BR_BLT  = 4'd4;
  localparam logic [3:0] BR_BGE  = 4'd5;
  localparam logic [3:0] BR_BLTU = 4'd6;
  localparam logic [3:0] BR_BGEU = 4'd7;
  localparam logic [3:0] BR_NONE = 4'd8;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;
  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction
  function automatic int tag_w(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction
endpackage

// File: rtl/branch_predictor_resolve.sv
// br_resolve: resolves branch direction and the architecturally correct next PC
module br_resolve
  import branch_predictor_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      br_type,
  input  logic [XLEN-1:0] src0,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] target,
  output logic            taken,
  output logic [XLEN-1:0] actual
);
  logic eq, lt, ltu;
  // direction per branch type, then the PC that execution really continues at
  always_comb begin
    eq = src0 == src1;
    lt = $signed(src0) < $signed(src1);
    ltu = src0 < src1;
    taken = (br_type == BR_JAL || br_type == BR_JALR) ? 1'b1 :
            br_type == BR_BEQ  ? eq   :
            br_type == BR_BNE  ? !eq  :
            br_type == BR_BLT  ? lt   :
            br_type == BR_BGE  ? !lt  :
            br_type == BR_BLTU ? ltu  :
            br_type == BR_BGEU ? !ltu : 1'b0;
    actual = !taken ? pc + XLEN'(4) :
             br_type == BR_JALR ? (target & ~XLEN'(1)) : target;
  end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, EX resolution, redirect and statistics
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int STAT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   if_pc,
  output logic [XLEN-1:0]   pred_npc,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [3:0]        ex_br_type,
  input  logic [XLEN-1:0]   ex_br_src0,
  input  logic [XLEN-1:0]   ex_br_src1,
  input  logic [XLEN-1:0]   ex_target,
  input  logic [XLEN-1:0]   ex_pred_npc,
  output logic              redirect,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              ex_taken,
  output logic [STAT_W-1:0] stat_br,
  output logic [STAT_W-1:0] stat_mis
);
  localparam int IDX_W = idx_w(ENTRIES);
  localparam int TAG_W = tag_w(XLEN, ENTRIES);
  logic [ENTRIES-1:0] valid_q, jmp_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  logic [1:0]         cnt_q [ENTRIES];
  logic [IDX_W-1:0]   if_idx, ex_idx;
  logic [TAG_W-1:0]   if_tag, ex_tag;
  logic               if_hit, ex_hit, is_br, taken;
  logic [XLEN-1:0]    actual, tkn_tgt;
  logic [1:0]         ex_cnt, cnt_nxt;
  br_resolve #(.XLEN(XLEN)) u_resolve (
    .br_type(ex_br_type),
    .src0(ex_br_src0),
    .src1(ex_br_src1),
    .pc(ex_pc),
    .target(ex_target),
    .taken(taken),
    .actual(actual)
  );
  // same-cycle prediction from pre-edge table contents, plus EX-side lookup and outcome
  always_comb begin
    if_idx = if_pc[IDX_W+1:2];
    if_tag = if_pc[XLEN-1:IDX_W+2];
    ex_idx = ex_pc[IDX_W+1:2];
    ex_tag = ex_pc[XLEN-1:IDX_W+2];
    if_hit = valid_q[if_idx] && tag_q[if_idx] == if_tag;
    ex_hit = valid_q[ex_idx] && tag_q[ex_idx] == ex_tag;
    pred_taken = if_hit && (jmp_q[if_idx] || cnt_q[if_idx][1]);
    pred_npc = pred_taken ? tgt_q[if_idx] : if_pc + XLEN'(4);
    is_br = ex_br_type < BR_NONE;
    tkn_tgt = ex_br_type == BR_JALR ? (ex_target & ~XLEN'(1)) : ex_target;
    ex_cnt = cnt_q[ex_idx];
    cnt_nxt = taken ? (ex_cnt == ST ? ST : ex_cnt + 2'd1) : (ex_cnt == SNT ? SNT : ex_cnt - 2'd1);
    ex_taken = ex_valid && taken;
    redirect = ex_valid && actual != ex_pred_npc;
    redirect_pc = actual;
  end
  // table training: update on hit, allocate on taken miss, drop false hits on non-branches
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= WNT;
    end else if (ex_valid && is_br && ex_hit) begin
      tgt_q[ex_idx] <= tkn_tgt;
      jmp_q[ex_idx] <= ex_br_type <= BR_JALR;
      cnt_q[ex_idx] <= cnt_nxt;
    end else if (ex_valid && is_br && taken) begin
      valid_q[ex_idx] <= 1'b1;
      tag_q[ex_idx] <= ex_tag;
      tgt_q[ex_idx] <= tkn_tgt;
      jmp_q[ex_idx] <= ex_br_type <= BR_JALR;
      cnt_q[ex_idx] <= WT;
    end else if (ex_valid && !is_br && redirect) begin
      valid_q[ex_idx] <= 1'b0;
    end
  end
  // saturating statistics for the debug bus
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br <= '0;
      stat_mis <= '0;
    end else begin
      if (ex_valid && is_br && !(&stat_br)) stat_br <= stat_br + STAT_W'(1);
      if (redirect && !(&stat_mis)) stat_mis <= stat_mis + STAT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vectors with a queued scoreboard checked by a separate monitor
module tb_branch_predictor;
  import branch_predictor_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = '0, ex_pc = '0, ex_br_src0 = '0, ex_br_src1 = '0, ex_target = '0, ex_pred_npc = '0;
  logic [3:0]  ex_br_type = BR_NONE;
  logic        ex_valid = 1'b0;
  logic [31:0] pred_npc, redirect_pc, stat_br, stat_mis;
  logic        pred_taken, redirect, ex_taken;
  logic [31:0] s_pred_npc, s_redirect_pc;
  logic        s_pred_taken, s_redirect, s_ex_taken;
  logic [1:0]  s_stat_br, s_stat_mis;
  typedef struct {string name; int sel; logic [31:0] val;} exp_t;
  exp_t        q[$];
  exp_t        e;
  logic [31:0] act;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_npc(pred_npc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_br_type(ex_br_type), .ex_br_src0(ex_br_src0),
    .ex_br_src1(ex_br_src1), .ex_target(ex_target), .ex_pred_npc(ex_pred_npc),
    .redirect(redirect), .redirect_pc(redirect_pc), .ex_taken(ex_taken),
    .stat_br(stat_br), .stat_mis(stat_mis)
  );

  branch_predictor #(.STAT_W(2)) dut_small (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_npc(s_pred_npc), .pred_taken(s_pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_br_type(ex_br_type), .ex_br_src0(ex_br_src0),
    .ex_br_src1(ex_br_src1), .ex_target(ex_target), .ex_pred_npc(ex_pred_npc),
    .redirect(s_redirect), .redirect_pc(s_redirect_pc), .ex_taken(s_ex_taken),
    .stat_br(s_stat_br), .stat_mis(s_stat_mis)
  );

  // monitor: outputs are stable mid-cycle, drain every expectation queued for this cycle
  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.sel)
        0: act = pred_npc;
        1: act = {31'b0, pred_taken};
        2: act = {31'b0, redirect};
        3: act = redirect_pc;
        4: act = {31'b0, ex_taken};
        5: act = stat_br;
        6: act = stat_mis;
        default: act = {30'b0, s_stat_mis};
      endcase
      vectors++;
      if (act !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic cyc(input logic r, input logic v, input logic [31:0] ifp, input logic [31:0] pc,
                     input logic [3:0] t, input logic [31:0] s0, input logic [31:0] s1,
                     input logic [31:0] tg, input logic [31:0] pn);
    @(posedge clk);
    #1;
    rst = r; ex_valid = v; if_pc = ifp; ex_pc = pc; ex_br_type = t;
    ex_br_src0 = s0; ex_br_src1 = s1; ex_target = tg; ex_pred_npc = pn;
  endtask

  task automatic idle(input logic [31:0] ifp);
    cyc(1'b0, 1'b0, ifp, 32'h0, BR_NONE, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic exp(input string n, input int s, input logic [31:0] v);
    q.push_back('{n, s, v});
  endtask

  task automatic exp_ex(input string n, input logic rd, input logic [31:0] rpc, input logic tk);
    exp({n, "_redirect"}, 2, {31'b0, rd});
    exp({n, "_redirect_pc"}, 3, rpc);
    exp({n, "_ex_taken"}, 4, {31'b0, tk});
  endtask

  task automatic exp_pred(input string n, input logic [31:0] npc, input logic tk);
    exp({n, "_pred_npc"}, 0, npc);
    exp({n, "_pred_taken"}, 1, {31'b0, tk});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(1'b1, 1'b0, 32'h0, 32'h0, BR_NONE, 32'h0, 32'h0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, BR_NONE, 32'h0, 32'h0, 32'h0, 32'h0);
    idle(32'h100);
    exp_pred("rst", 32'h104, 1'b0);
    exp("rst_stat_br", 5, 0); exp("rst_stat_mis", 6, 0); exp("rst_redirect", 2, 0);
    cyc(1'b0, 1'b1, 32'h100, 32'h100, BR_BEQ, 32'd5, 32'd5, 32'h80, 32'h104);
    exp_ex("beq_t", 1'b1, 32'h80, 1'b1);
    exp_pred("same_cycle_old", 32'h104, 1'b0);
    idle(32'h100);
    exp_pred("beq_alloc", 32'h80, 1'b1);
    exp("stat_mis1", 6, 1); exp("stat_br1", 5, 1);
    cyc(1'b0, 1'b1, 32'h100, 32'h100, BR_BEQ, 32'd1, 32'd2, 32'h80, 32'h80);
    exp_ex("beq_nt1", 1'b1, 32'h104, 1'b0);
    idle(32'h100);
    exp_pred("cnt01", 32'h104, 1'b0);
    exp("stat_mis2", 6, 2); exp("stat_br2", 5, 2);
    cyc(1'b0, 1'b1, 32'h100, 32'h100, BR_BEQ, 32'd1, 32'd2, 32'h80, 32'h104);
    exp_ex("beq_nt2", 1'b0, 32'h104, 1'b0);
    cyc(1'b0, 1'b1, 32'h100, 32'h100, BR_BEQ, 32'd1, 32'd2, 32'h80, 32'h104);
    exp_ex("beq_nt3", 1'b0, 32'h104, 1'b0);
    cyc(1'b0, 1'b1, 32'h100, 32'h100, BR_BEQ, 32'd7, 32'd7, 32'h80, 32'h104);
    exp_ex("beq_t2", 1'b1, 32'h80, 1'b1);
    idle(32'h100);
    exp_pred("cnt_sat_low", 32'h104, 1'b0);
    exp("stat_br5", 5, 5); exp("stat_mis3", 6, 3); exp("small_mis3", 7, 3);
    cyc(1'b0, 1'b1, 32'h200, 32'h200, BR_JALR, 32'h0, 32'h0, 32'h3001, 32'h204);
    exp_ex("jalr", 1'b1, 32'h3000, 1'b1);
    idle(32'h200);
    exp_pred("jalr_pred", 32'h3000, 1'b1);
    exp("small_mis_sat1", 7, 3); exp("stat_mis4", 6, 4);
    idle(32'h100);
    exp_pred("alias_evict", 32'h104, 1'b0);
    cyc(1'b0, 1'b1, 32'h200, 32'h200, BR_NONE, 32'h0, 32'h0, 32'h0, 32'h3000);
    exp_ex("false_hit", 1'b1, 32'h204, 1'b0);
    idle(32'h200);
    exp_pred("false_hit_clr", 32'h204, 1'b0);
    exp("stat_br6", 5, 6); exp("stat_mis5", 6, 5); exp("small_mis_sat2", 7, 3);
    cyc(1'b0, 1'b1, 32'h300, 32'h300, 4'd15, 32'h0, 32'h0, 32'h0, 32'h304);
    exp_ex("type15", 1'b0, 32'h304, 1'b0);
    cyc(1'b0, 1'b1, 32'h400, 32'h400, BR_BLT, 32'hffffffff, 32'd1, 32'h500, 32'h404);
    exp_ex("blt", 1'b1, 32'h500, 1'b1);
    cyc(1'b0, 1'b1, 32'h400, 32'h600, BR_BLTU, 32'hffffffff, 32'd1, 32'h700, 32'h604);
    exp_ex("bltu", 1'b0, 32'h604, 1'b0);
    exp_pred("blt_pred", 32'h500, 1'b1);
    cyc(1'b0, 1'b1, 32'h0, 32'h800, BR_BGE, 32'd1, 32'hffffffff, 32'h900, 32'h804);
    exp_ex("bge", 1'b1, 32'h900, 1'b1);
    cyc(1'b0, 1'b1, 32'h0, 32'ha00, BR_BGEU, 32'd1, 32'hffffffff, 32'hb00, 32'ha04);
    exp_ex("bgeu", 1'b0, 32'ha04, 1'b0);
    cyc(1'b0, 1'b1, 32'h0, 32'hb00, BR_BNE, 32'd3, 32'd4, 32'hc00, 32'hc00);
    exp_ex("bne", 1'b0, 32'hc00, 1'b1);
    cyc(1'b0, 1'b1, 32'h0, 32'hd00, BR_JAL, 32'h0, 32'h0, 32'he01, 32'he01);
    exp_ex("jal", 1'b0, 32'he01, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 32'h100, BR_BEQ, 32'd1, 32'd1, 32'h80, 32'h0);
    exp_ex("ex_invalid", 1'b0, 32'h80, 1'b0);
    idle(32'hd00);
    exp_pred("jal_pred", 32'he01, 1'b1);
    exp("stat_br12", 5, 12); exp("stat_mis7", 6, 7); exp("small_mis_sat3", 7, 3);
    cyc(1'b1, 1'b1, 32'hd00, 32'h1000, BR_JAL, 32'h0, 32'h0, 32'h2000, 32'h1004);
    exp_ex("rst_upd", 1'b1, 32'h2000, 1'b1);
    idle(32'h1000);
    exp_pred("rst_no_alloc", 32'h1004, 1'b0);
    exp("rst2_stat_br", 5, 0); exp("rst2_stat_mis", 6, 0);
    idle(32'hd00);
    exp_pred("rst_cleared", 32'hd04, 1'b0);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
